mux4_scan_sequencer: RTL and testbench
======================================

# mux4_scan_sequencer

Scan controller that sits directly upstream of the 4:1 mux. It drives the mux `sel` lines through the enabled channels in ascending order and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux output `y` back in and assembles the four captured bits into a frame word. It replaces the free-running `sel` counter used so far with a controlled, maskable, handshaked scan.

## Interface
- `DWELL_W`, default 4: width of the dwell count. Per-channel hold time is `dwell`+1 cycles.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan. Sampled only in IDLE.
- `stop`  in  1: abort the scan at the next edge. Returns to IDLE with no frame output.
- `continuous`  in  1: latched at start. 1 restarts the scan after each frame.
- `en_mask`  in  4: channel enables, bit i = channel i. Latched at start.
- `dwell`  in  DWELL_W: hold count. Latched at start.
- `y_in`  in  1: mux output `y`, fed back combinationally.
- `sel`  out  2: to mux `sel`. Bit 1 selects the c/d pair, bit 0 selects within the pair.
- `busy`  out  1: high while in RUN.
- `sample_valid`  out  1: one-cycle pulse per captured channel.
- `sample_ch`  out  2: channel of the current sample.
- `sample_bit`  out  1: captured value.
- `frame`  out  4: captured bits, bit i = channel i. Disabled channels read 0.
- `frame_valid`  out  1: one-cycle pulse when `frame` is updated.

## Operation
- States: IDLE, RUN.
- **IDLE → RUN:** requires `start`=1 and `en_mask`≠0. On that edge:
  - latch `en_mask`, `dwell` and `continuous`;
  - set `sel` to the lowest enabled channel;
  - clear the dwell counter and the frame accumulator.
- **Ignored starts:** `start` with `en_mask`=0 is ignored, and the block stays in IDLE. `start` while in RUN is ignored.
- **Dwell counting in RUN:** the dwell counter increments each edge until it equals the latched `dwell`.
- **Capture edge** (counter equals `dwell`):
  - capture `y_in` into the accumulator bit `sel` and into `sample_bit`;
  - set `sample_ch`=`sel` and pulse `sample_valid`;
  - if higher enabled channels remain, advance `sel` to the next one and clear the counter;
  - if `sel` was the highest enabled channel:
    - copy the accumulator to `frame` and pulse `frame_valid`, in the same cycle as that channel's `sample_valid`;
    - if `continuous`=1, wrap `sel` to the lowest enabled channel, clear the accumulator, and stay in RUN;
    - otherwise go to IDLE.
- **Abort:** `stop` in RUN forces IDLE on that edge. No sample and no frame are produced, even if it coincides with a capture edge, because `stop` wins. `frame` keeps its previous value.
- **Sel in IDLE:** `sel` holds its last value.
- **Reset:** overrides everything.
- **Reset values:**
  - `sel`=0, `busy`=0, `sample_valid`=0, `sample_ch`=0, `sample_bit`=0, `frame`=0, `frame_valid`=0;
  - state IDLE, counter 0, accumulator 0.
- **Live inputs ignored:** changes to `en_mask`, `dwell` or `continuous` during RUN have no effect until the next start.

## Timing
- Start accepted at edge E0. `sel` is valid, and `busy`=1, from the cycle after E0.
- Capture edge for the first channel is E0+`dwell`+1. `sample_valid` is high in the following cycle.
- Each subsequent enabled channel captures `dwell`+1 edges after the previous one. There is no gap cycle between channels, and none at a continuous wrap.
- Frame latency from start is N·(`dwell`+1) edges, where N is the popcount of the latched mask.
- Non-continuous: `busy` falls at the same edge that raises `frame_valid`. A new `start` can be accepted at the next edge.
- `y_in` must be settled within the cycle, since the mux is combinational and has zero latency.

## Structure
- **Shared package `mux4_scan_pkg`:**
  - state enum {IDLE, RUN};
  - constants NCH=4 and SEL_W=2.
- **Sub-module `rr_next_ch`:** combinational. Inputs are the mask and the current channel. Outputs are the next higher enabled channel, a `last` flag, and the lowest enabled channel. It is used for the start, advance and wrap decisions.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-scan → all outputs at reset values. `busy`=0 on the next cycle, and no pulses follow.
- **Full mask, no dwell:** mux data a=1, b=0, c=1, d=0; `en_mask`=1111, `dwell`=0, `continuous`=0; start.
  - `sel` = 0, 1, 2, 3 on consecutive cycles;
  - samples 1, 0, 1, 0 on 4 consecutive `sample_valid` cycles;
  - `frame`=0101 with `frame_valid` on the 4th sample;
  - `busy` low afterwards.
- **Sparse mask, dwell 3:** `en_mask`=1010, `dwell`=3, b=1, d=1.
  - `sel`=1 for 4 cycles, then 3 for 4 cycles;
  - `sample_ch` 1 then 3, spaced 4 cycles apart;
  - `frame`=1010.
- **Continuous scan:** `continuous`=1, `en_mask`=0110, `dwell`=1; toggle c between frames.
  - `frame_valid` every 4 cycles;
  - `sel` wraps 2→1 with no gap;
  - the second frame reflects the new c value.
- **Abort:** `stop` on a capture edge → no `sample_valid`, `frame` unchanged, IDLE next cycle.
- **Ignored starts:**
  - `start` with `en_mask`=0 → stays IDLE;
  - `start` pulsed during RUN → scan timing unchanged.

Source files
------------

// File: rtl/mux4_scan_pkg.sv
// mux4_scan_pkg: shared state type and channel constants for the mux4 scan sequencer
package mux4_scan_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int NCH = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/mux4_scan_sequencer_rr_next_ch.sv
// rr_next_ch: next higher enabled channel, last flag and lowest enabled channel of a mask
module rr_next_ch
  import mux4_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             last,
  output logic [SEL_W-1:0] first
);
  always_comb begin
    first = '0;
    nxt = cur;
    last = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
      if (mask[i] && i > int'(cur)) begin
        nxt = SEL_W'(i);
        last = 1'b0;
      end
    end
  end
endmodule

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: maskable, dwell-timed scan of a 4:1 mux sel with per-channel capture and frame assembly
module mux4_scan_sequencer
  import mux4_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NCH-1:0]     en_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               sample_valid,
  output logic [SEL_W-1:0]   sample_ch,
  output logic               sample_bit,
  output logic [NCH-1:0]     frame,
  output logic               frame_valid
);
  state_t state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [NCH-1:0] mask_q, mask_d, acc_q, acc_d, frame_q, frame_d, cap, rr_mask;
  logic [SEL_W-1:0] sel_q, sel_d, sch_q, sch_d, nxt, first;
  logic cont_q, cont_d, sv_q, sv_d, sb_q, sb_d, fv_q, fv_d, last;
  assign rr_mask = (state_q == IDLE) ? en_mask : mask_q;
  assign cap = acc_q | (NCH'(y_in) << sel_q);
  rr_next_ch u_rr (.mask(rr_mask), .cur(sel_q), .nxt(nxt), .last(last), .first(first));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dwell_d = dwell_q;
    mask_d = mask_q;
    acc_d = acc_q;
    frame_d = frame_q;
    sel_d = sel_q;
    sch_d = sch_q;
    cont_d = cont_q;
    sb_d = sb_q;
    sv_d = 1'b0;
    fv_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && |en_mask) begin
        state_d = RUN;
        mask_d = en_mask;
        dwell_d = dwell;
        cont_d = continuous;
        sel_d = first;
        cnt_d = '0;
        acc_d = '0;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (cnt_q == dwell_q) begin
      sv_d = 1'b1;
      sb_d = y_in;
      sch_d = sel_q;
      acc_d = cap;
      cnt_d = '0;
      if (!last) begin
        sel_d = nxt;
      end else begin
        frame_d = cap;
        fv_d = 1'b1;
        acc_d = '0;
        sel_d = cont_q ? first : sel_q;
        state_d = cont_q ? RUN : IDLE;
      end
    end else begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dwell_q <= '0;
      mask_q <= '0;
      acc_q <= '0;
      frame_q <= '0;
      sel_q <= '0;
      sch_q <= '0;
      cont_q <= 1'b0;
      sv_q <= 1'b0;
      sb_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dwell_q <= dwell_d;
      mask_q <= mask_d;
      acc_q <= acc_d;
      frame_q <= frame_d;
      sel_q <= sel_d;
      sch_q <= sch_d;
      cont_q <= cont_d;
      sv_q <= sv_d;
      sb_q <= sb_d;
      fv_q <= fv_d;
    end
  end
  assign sel = sel_q;
  assign busy = (state_q == RUN);
  assign sample_valid = sv_q;
  assign sample_ch = sch_q;
  assign sample_bit = sb_q;
  assign frame = frame_q;
  assign frame_valid = fv_q;
endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb_mux4_scan_sequencer: directed and randomized checks against a timeline-based reference model
module tb_mux4_scan_sequencer;
  logic clk = 0, rst = 1, start = 0, stop = 0, continuous = 0, y_in;
  logic [3:0] en_mask = 0, data = 0, frame;
  logic [3:0] dwell = 0;
  logic [1:0] sel, sample_ch;
  logic busy, sample_valid, sample_bit, frame_valid;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign y_in = data[sel];

  mux4_scan_sequencer #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .en_mask(en_mask), .dwell(dwell), .y_in(y_in), .sel(sel), .busy(busy),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_bit(sample_bit),
    .frame(frame), .frame_valid(frame_valid)
  );

  // Reference: a scan is a list of enabled channels and an edge count t since start;
  // channel k of the list is captured at t = (k+1)*(dwell+1) (mod the frame period).
  int chans[$];
  int t = 0, per = 1, nch = 0;
  bit m_run = 0, m_cont = 0, m_sv = 0, m_fv = 0, m_bit = 0;
  logic [1:0] m_sel = 0, m_ch = 0;
  logic [3:0] m_acc = 0, m_frame = 0;

  always @(posedge clk) begin
    int k, ch;
    m_sv = 0;
    m_fv = 0;
    if (rst) begin
      m_run = 0; m_sel = 0; m_ch = 0; m_bit = 0; m_acc = 0; m_frame = 0;
    end else if (!m_run) begin
      if (start && en_mask != 0) begin
        chans.delete();
        for (int i = 0; i < 4; i++) if (en_mask[i]) chans.push_back(i);
        nch = chans.size();
        per = int'(dwell) + 1;
        m_cont = continuous;
        t = 0;
        m_acc = 0;
        m_sel = 2'(chans[0]);
        m_run = 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      t++;
      if (t % per == 0) begin
        k = (t / per - 1) % nch;
        ch = chans[k];
        m_sv = 1;
        m_ch = 2'(ch);
        m_bit = data[ch];
        m_acc[ch] = data[ch];
        if (k == nch - 1) begin
          m_frame = m_acc;
          m_fv = 1;
          m_acc = 0;
          if (!m_cont) m_run = 0;
        end
      end
      if (m_run) m_sel = 2'(chans[(t / per) % nch]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("sel", sel, m_sel);
      check("busy", busy, m_run);
      check("sample_valid", sample_valid, m_sv);
      check("sample_ch", sample_ch, m_ch);
      check("sample_bit", sample_bit, m_bit);
      check("frame", frame, m_frame);
      check("frame_valid", frame_valid, m_fv);
    end
  endtask

  task automatic go(input logic [3:0] m, input logic [3:0] d, input logic c);
    en_mask = m; dwell = d; continuous = c; start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    rst = 1;
    tick(2);
    check("reset_busy", busy, 0);
    check("reset_frame", frame, 0);
    rst = 0;
    tick();
    // full mask, zero dwell: a=1 b=0 c=1 d=0
    data = 4'b0101;
    go(4'b1111, 0, 0);
    check("full_sel0", sel, 0);
    tick(4);
    check("full_frame", frame, 4'b0101);
    check("full_fv", frame_valid, 1);
    tick(2);
    check("full_idle", busy, 0);
    // sparse mask, dwell 3
    data = 4'b1010;
    go(4'b1010, 3, 0);
    tick(8);
    check("sparse_frame", frame, 4'b1010);
    tick(2);
    // continuous with c toggling between frames, plus an ignored start mid-run
    data = 4'b0100;
    go(4'b0110, 1, 1);
    tick(3);
    start = 1; tick(); start = 0;
    data[2] = 0;
    tick(4);
    check("cont_frame2", frame, 4'b0000);
    data[2] = 1;
    tick(4);
    check("cont_frame3", frame, 4'b0100);
    stop = 1; tick(); stop = 0;
    check("cont_stopped", busy, 0);
    tick(2);
    // abort exactly on the first capture edge
    data = 4'b1111;
    go(4'b1111, 2, 0);
    tick(2);
    stop = 1; tick(); stop = 0;
    check("abort_no_sv", sample_valid, 0);
    check("abort_frame", frame, 4'b0100);
    check("abort_idle", busy, 0);
    tick(3);
    // start with empty mask is ignored
    go(4'b0000, 0, 0);
    check("empty_idle", busy, 0);
    tick(2);
    // reset for two cycles mid-scan
    go(4'b1011, 2, 1);
    tick(5);
    rst = 1; tick(2); rst = 0;
    check("midrst_frame", frame, 0);
    tick(4);
    check("midrst_busy", busy, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      data = 4'($urandom);
      start = ($urandom % 6) == 0;
      stop = ($urandom % 50) == 0;
      rst = ($urandom % 400) == 0;
      en_mask = 4'($urandom);
      dwell = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 3);
      continuous = ($urandom % 3) == 0;
      tick();
    end
    rst = 0; start = 0; stop = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
